// File: rtl/metro_mpi_pkg.sv
// Shared types and sizing helpers for the Metro-MPI link endpoint.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default flit width, default receive depth, flit_t, and cnt_w()
// which sizes an occupancy counter able to hold 0..depth inclusive.
package metro_mpi_pkg;

  localparam int FLIT_W           = 64;
  localparam int RX_DEPTH_DEFAULT = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  // Occupancy counters must represent DEPTH itself (full), hence depth+1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/metro_sync_fifo.sv
// Synchronous FIFO with registered storage, pointers and occupancy count.
// Latency: a push in cycle N is visible at head_o from cycle N+1 (no fall-through).
// Backpressure: none internally; caller must not push when full_o or pop when empty_o.
//
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset (clears storage too)
//   push_i, data_i     write request and payload
//   pop_i              read request, advances head
//   head_o             entry at read pointer (raw, not qualified by empty)
//   count_o            current occupancy, 0..DEPTH
//   full_o, empty_o    occupancy flags
module metro_sync_fifo
  import metro_mpi_pkg::*;
#(
  parameter int DATA_W = FLIT_W,
  parameter int DEPTH  = RX_DEPTH_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      push_i,
  input  logic [DATA_W-1:0]         data_i,
  input  logic                      pop_i,
  output logic [DATA_W-1:0]         head_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("metro_sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rstn_i)
    count_q <= CNT_W'(DEPTH));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(pop_i && empty_o));

endmodule

// File: rtl/metro_credit_rx.sv
// Credit-based link receiver: buffers link flits, hands them to a valid/ready consumer.
// Latency: flit visible one cycle after arrival; yummy (credit) one cycle after each pop.
// Backpressure: consumer stalls via ready_i; link is credit-limited, a flit arriving full is dropped and flagged.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   rank_i               rank of this process; block only acts when it equals RX_RANK
//   valid_i, data_i      inbound link flit
//   yummy_o              one-cycle credit return per consumed flit
//   valid_o, data_o      head flit to consumer (data_o forced 0 when not valid)
//   ready_i              consumer accepts head flit
//   count_o              FIFO occupancy
//   overflow_o           sticky: flit arrived while FIFO full
module metro_credit_rx
  import metro_mpi_pkg::*;
#(
  parameter int DATA_W  = FLIT_W,
  parameter int DEPTH   = RX_DEPTH_DEFAULT,
  parameter int RX_RANK = 0
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  int                       rank_i,
  input  logic                     valid_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     yummy_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  input  logic                     ready_i,
  output logic [cnt_w(DEPTH)-1:0]  count_o,
  output logic                     overflow_o
);

  logic              active;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic              yummy_q, yummy_d;
  logic              overflow_q, overflow_d;

  assign active = (rank_i == RX_RANK);

  // Inactive ranks freeze: no push, no pop, no overflow update.
  assign push    = active & valid_i & ~full;
  assign valid_o = active & ~empty;
  assign pop     = valid_o & ready_i;
  assign data_o  = valid_o ? head : '0;

  metro_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .data_i  (data_i),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // A flit while full means the sender spent a credit it did not hold.
  always_comb begin
    yummy_d    = pop;
    overflow_d = overflow_q | (active & valid_i & full);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yummy_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      yummy_q    <= yummy_d;
      overflow_q <= overflow_d;
    end
  end

  // Credit pulse is suppressed on a non-matching rank like every other output.
  assign yummy_o    = active & yummy_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/metro_credit_rx.md
Name: metro_credit_rx

Overview:
- Parametrised credit-based link receiver for the Metro-MPI endpoint; successor to the fixed single-slot, fixed-64-bit receiver.
- Accepts flits from the inter-rank link into a DEPTH-entry FIFO and presents them to the local consumer over valid/ready.
- Returns one yummy (credit) pulse to the sender per flit consumed.
- Detects credit-protocol violations and exposes occupancy; active only on the configured rank.

Parameters:
- DATA_W, 64, flit width in bits
- DEPTH, 4, FIFO entries and initial sender credit; power of two, >= 2
- RX_RANK, 0, rank on which the block is active

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- rank_i  in  32 (int)  rank of this simulation process
- valid_i  in  1  link flit valid; sender guarantees it held a credit
- data_i  in  DATA_W  link flit payload
- yummy_o  out  1  credit-return pulse to sender, one per consumed flit
- valid_o  out  1  head flit available to consumer
- data_o  out  DATA_W  head flit payload
- ready_i  in  1  consumer accepts head flit
- count_o  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow_o  out  1  sticky: flit arrived while FIFO full

Behaviour:
- One clock clk_i; reset rstn_i is asynchronous, active-low.
- Reset values:
  - yummy_o=0, valid_o=0, data_o=0, count_o=0, overflow_o=0.
  - Read/write pointers=0; storage cleared to 0.
- active = (rank_i == RX_RANK). When inactive:
  - No push, no pop; state holds.
  - yummy_o=0, valid_o=0, data_o=0.
- push = active & valid_i & !full. Writes data_i at wr_ptr; wr_ptr advances mod DEPTH.
- valid_i & full: flit dropped, overflow_o set (sticky until reset), state otherwise unchanged.
  - Push while full is always a violation: the sender regains credit only after yummy, which is issued after a pop.
- No fall-through: a flit pushed in cycle N is visible on valid_o/data_o from cycle N+1.
- valid_o = active & !empty; data_o = mem[rd_ptr] when valid_o, else 0.
- pop = valid_o & ready_i. rd_ptr advances mod DEPTH.
- yummy_o is registered: high in cycle N+1 iff pop in cycle N. Consecutive pops give consecutive yummy cycles; no coalescing.
- count_o = count_q.
  - count_d = count_q + push - pop.
  - Simultaneous push and pop leave count unchanged; both pointers advance.
- full = (count_q == DEPTH); empty = (count_q == 0). Pointers are $clog2(DEPTH) bits and wrap naturally.
- Simultaneous push and pop when empty: impossible (pop needs !empty); the pushed flit appears next cycle.
- Reset mid-operation: all buffered flits discarded; the sender side is reset on the same rstn_i, so credits restart at DEPTH.
- Invariant, checked by assertion: count_q <= DEPTH.
- Occupancy never exceeds outstanding credits in a compliant system.

Decomposition:
- metro_mpi_pkg:
  - FLIT_W default constant (64) and RX_DEPTH_DEFAULT (4).
  - flit_t typedef (logic [FLIT_W-1:0]).
  - cnt_t width function/localparam.
- One sub-module: metro_sync_fifo (DATA_W, DEPTH).
  - Pointers, storage, count, full/empty.
  - push/pop in, head out.
- metro_credit_rx adds:
  - Rank gating.
  - Overflow detection.
  - Registered yummy generation.

Test Plan:
- Reset then idle, rank_i=0 → valid_o=0, count_o=0, yummy_o=0, overflow_o=0.
- rank_i=0, ready_i=0; push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles → count_o=4, valid_o=1, data_o=0xA1. Then ready_i=1 for 4 cycles → data_o 0xA1..0xA4 in order; yummy_o high 4 cycles, each lagging its pop by one cycle; count_o returns to 0.
- FIFO full (DEPTH=4), valid_i with 0xFF → overflow_o=1 and stays 1; count_o stays 4; later pops never output 0xFF.
- Steady stream, push and pop every cycle for 10 cycles with pointer wrap → count_o constant at 1; outputs match input order; 10 yummy pulses.
- rank_i=1 with valid_i=1 data 0x55 → count_o=0, valid_o=0, yummy_o=0. Switch rank_i=0 and repeat → flit accepted.
- Reset asserted with count_o=3 mid-drain → all outputs 0 immediately (asynchronous). After release, push 0x77 → data_o=0x77 next cycle.
- Parameter sweep DATA_W=32, DEPTH=8 → 8 flits accepted without overflow, 9th sets overflow_o.
